// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: FSM states, request sources and
// the store-size/offset legality and strobe rule.
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    HOLD_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_IMEM   = 2'd0,
    SRC_DREAD  = 2'd1,
    SRC_DWRITE = 2'd2
  } src_t;

  // Returns {legal, strb[3:0]}; an illegal size/offset pair yields all zeros.
  function automatic logic [4:0] store_strobe(input logic [2:0] wlen, input logic [1:0] off);
    logic [4:0] r;
    r = '0;
    case (wlen)
      3'd1: r = {1'b1, 4'b0001 << off};
      3'd2: if (!off[0]) r = {1'b1, 4'b0011 << off};
      3'd4: if (off == 2'b00) r = 5'b11111;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_mem_store_align.sv
// Combinational store lane alignment: shifts LSB-justified store data into its
// byte lanes, zeroes lanes outside the strobe and reports size/offset legality.
module cpu_mem_store_align
  import cpu_mem_arbiter_pkg::*;
(
  input  logic [2:0]  wlen,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic        legal,
  output logic [3:0]  strb,
  output logic [31:0] wdata_aligned
);

  logic [4:0]  chk;
  logic [31:0] shifted;

  assign chk     = store_strobe(wlen, off);
  assign legal   = chk[4];
  assign strb    = chk[3:0];
  assign shifted = wdata << {off, 3'b000};

  // Disabled lanes are driven to zero so stale upper bits never reach memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_aligned[8*gi +: 8] = strb[gi] ? shifted[8*gi +: 8] : 8'h00;
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges the imem read, dmem read and dmem write channels onto one memory
// port, one transaction at a time, with a response timeout for forward progress.
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hdeadbeef
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] imem_addr,
  input  logic        imem_valid,
  output logic        imem_ready,
  output logic [31:0] imem_rdata,
  output logic        imem_rdata_valid,
  input  logic        imem_rdata_ready,

  input  logic [31:0] dmem_raddr,
  input  logic        dmem_rvalid,
  output logic        dmem_rready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_rdata_valid,
  input  logic        dmem_rdata_ready,

  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [2:0]  dmem_wlen,
  input  logic        dmem_wvalid,
  output logic        dmem_wready,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,

  output logic        err_misaligned,
  output logic        err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   WORD_MASK = 32'hffff_fffc;

  state_t      state_reg;
  src_t        src_reg;
  logic [CW-1:0] cnt_reg;

  logic        mem_req_reg;
  logic        mem_we_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_wstrb_reg;

  logic [31:0] imem_rdata_reg;
  logic        imem_rdata_valid_reg;
  logic [31:0] dmem_rdata_reg;
  logic        dmem_rdata_valid_reg;

  logic        err_misaligned_reg;
  logic        err_timeout_reg;

  logic        st_legal;
  logic [3:0]  st_strb;
  logic [31:0] st_wdata;

  cpu_mem_store_align u_store_align (
    .wlen          (dmem_wlen),
    .off           (dmem_waddr[1:0]),
    .wdata         (dmem_wdata),
    .legal         (st_legal),
    .strb          (st_strb),
    .wdata_aligned (st_wdata)
  );

  // Fixed priority: store beats load beats fetch; only the winner sees ready.
  logic is_idle;
  assign is_idle     = (state_reg == IDLE);
  assign dmem_wready = is_idle && dmem_wvalid;
  assign dmem_rready = is_idle && dmem_rvalid && !dmem_wvalid;
  assign imem_ready  = is_idle && imem_valid && !dmem_wvalid && !dmem_rvalid;

  // Real read data always wins over a timeout landing in the same cycle.
  logic        rsp_fire;
  logic [31:0] rsp_data;
  logic        rsp_ready;
  assign rsp_fire  = mem_rvalid || (cnt_reg == CNT_LAST);
  assign rsp_data  = mem_rvalid ? mem_rdata : ERR_DATA;
  assign rsp_ready = (src_reg == SRC_IMEM) ? imem_rdata_ready : dmem_rdata_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg            <= IDLE;
      src_reg              <= SRC_IMEM;
      cnt_reg              <= '0;
      mem_req_reg          <= 1'b0;
      mem_we_reg           <= 1'b0;
      mem_addr_reg         <= '0;
      mem_wdata_reg        <= '0;
      mem_wstrb_reg        <= '0;
      imem_rdata_reg       <= '0;
      imem_rdata_valid_reg <= 1'b0;
      dmem_rdata_reg       <= '0;
      dmem_rdata_valid_reg <= 1'b0;
      err_misaligned_reg   <= 1'b0;
      err_timeout_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (dmem_wvalid) begin
            if (st_legal) begin
              state_reg     <= REQ;
              src_reg       <= SRC_DWRITE;
              mem_req_reg   <= 1'b1;
              mem_we_reg    <= 1'b1;
              mem_addr_reg  <= dmem_waddr & WORD_MASK;
              mem_wdata_reg <= st_wdata;
              mem_wstrb_reg <= st_strb;
            end else begin
              // Illegal store is acknowledged and dropped; flag it and stay put.
              err_misaligned_reg <= 1'b1;
            end
          end else if (dmem_rvalid) begin
            state_reg     <= REQ;
            src_reg       <= SRC_DREAD;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= dmem_raddr & WORD_MASK;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
          end else if (imem_valid) begin
            state_reg     <= REQ;
            src_reg       <= SRC_IMEM;
            mem_req_reg   <= 1'b1;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= imem_addr & WORD_MASK;
            mem_wdata_reg <= '0;
            mem_wstrb_reg <= '0;
          end
        end

        REQ: begin
          if (mem_gnt) begin
            mem_req_reg <= 1'b0;
            if (mem_we_reg) begin
              state_reg <= IDLE;
            end else begin
              state_reg <= WAIT_RESP;
              cnt_reg   <= '0;
            end
          end
        end

        WAIT_RESP: begin
          cnt_reg <= cnt_reg + CW'(1);
          if (rsp_fire) begin
            state_reg <= HOLD_RESP;
            if (src_reg == SRC_IMEM) begin
              imem_rdata_reg       <= rsp_data;
              imem_rdata_valid_reg <= 1'b1;
            end else begin
              dmem_rdata_reg       <= rsp_data;
              dmem_rdata_valid_reg <= 1'b1;
            end
            if (!mem_rvalid) err_timeout_reg <= 1'b1;
          end
        end

        HOLD_RESP: begin
          if (rsp_ready) begin
            state_reg            <= IDLE;
            imem_rdata_valid_reg <= 1'b0;
            dmem_rdata_valid_reg <= 1'b0;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_req          = mem_req_reg;
  assign mem_we           = mem_we_reg;
  assign mem_addr         = mem_addr_reg;
  assign mem_wdata        = mem_wdata_reg;
  assign mem_wstrb        = mem_wstrb_reg;
  assign imem_rdata       = imem_rdata_reg;
  assign imem_rdata_valid = imem_rdata_valid_reg;
  assign dmem_rdata       = dmem_rdata_reg;
  assign dmem_rdata_valid = dmem_rdata_valid_reg;
  assign err_misaligned   = err_misaligned_reg;
  assign err_timeout      = err_timeout_reg;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Scoreboard bench for cpu_mem_arbiter: directed stimulus pushes expected
// memory transactions and read responses; a negedge monitor pops and compares.
module tb_cpu_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic        imem_valid, imem_ready;
  logic [31:0] imem_rdata;
  logic        imem_rdata_valid, imem_rdata_ready;
  logic [31:0] dmem_raddr;
  logic        dmem_rvalid, dmem_rready;
  logic [31:0] dmem_rdata;
  logic        dmem_rdata_valid, dmem_rdata_ready;
  logic [31:0] dmem_waddr, dmem_wdata;
  logic [2:0]  dmem_wlen;
  logic        dmem_wvalid, dmem_wready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        err_misaligned, err_timeout;

  cpu_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(32'hdeadbeef)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .imem_rdata_valid(imem_rdata_valid), .imem_rdata_ready(imem_rdata_ready),
    .dmem_raddr(dmem_raddr), .dmem_rvalid(dmem_rvalid), .dmem_rready(dmem_rready),
    .dmem_rdata(dmem_rdata), .dmem_rdata_valid(dmem_rdata_valid), .dmem_rdata_ready(dmem_rdata_ready),
    .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wlen(dmem_wlen),
    .dmem_wvalid(dmem_wvalid), .dmem_wready(dmem_wready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_txn_t;

  mem_txn_t    exp_mem[$];
  logic [31:0] exp_imem[$];
  logic [31:0] exp_dmem[$];
  mem_txn_t    mon_e;
  logic [31:0] mon_d;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory contents seen by the responder (hand-picked words).
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h8000_0000: return 32'h0000_0413;
      32'h8000_0004: return 32'h0010_0093;
      32'h8000_2004: return 32'h1122_3344;
      32'h8000_3000: return 32'h5566_7788;
      default:       return 32'h0bad_c0de;
    endcase
  endfunction

  // Memory responder: grants after gnt_wait stall cycles, returns read data
  // rv_wait cycles after the cycle following the grant (-1: never answers).
  int          gnt_wait = 0;
  int          rv_wait  = 0;
  int          wait_cnt = 0;
  int          rd_cnt   = -1;
  logic [31:0] rd_data  = '0;
  logic [31:0] hold_addr = '0;

  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (rd_cnt > 0) begin
        rd_cnt--;
      end else if (rd_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_data;
        rd_cnt     = -1;
      end else if (mem_req && !rst) begin
        if (wait_cnt == 0) hold_addr = mem_addr;
        else check("req_addr_stable", mem_addr, hold_addr);
        if (wait_cnt < gnt_wait) begin
          wait_cnt++;
        end else begin
          mem_gnt  = 1'b1;
          wait_cnt = 0;
          if (!mem_we) begin
            rd_data = mem_model(mem_addr);
            rd_cnt  = rv_wait;
          end
        end
      end
    end
  end

  // Monitor: one line per observed transaction, compared against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt) begin
        $display("mem txn we=%0b addr=%h wdata=%h wstrb=%b", mem_we, mem_addr, mem_wdata, mem_wstrb);
        if (exp_mem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL mem_unexpected: got addr %h expected no transaction", mem_addr);
        end else begin
          mon_e = exp_mem.pop_front();
          check("mem_we", {31'b0, mem_we}, {31'b0, mon_e.we});
          check("mem_addr", mem_addr, mon_e.addr);
          if (mon_e.we) begin
            check("mem_wdata", mem_wdata, mon_e.wdata);
            check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, mon_e.wstrb});
          end
        end
      end
      if (imem_rdata_valid && imem_rdata_ready) begin
        $display("imem rsp data=%h", imem_rdata);
        if (exp_imem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL imem_unexpected: got %h expected no response", imem_rdata);
        end else begin
          mon_d = exp_imem.pop_front();
          check("imem_rdata", imem_rdata, mon_d);
        end
      end
      if (dmem_rdata_valid && dmem_rdata_ready) begin
        $display("dmem rsp data=%h", dmem_rdata);
        if (exp_dmem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL dmem_unexpected: got %h expected no response", dmem_rdata);
        end else begin
          mon_d = exp_dmem.pop_front();
          check("dmem_rdata", dmem_rdata, mon_d);
        end
      end
    end
  end

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
    tick();
    dmem_waddr = a; dmem_wdata = d; dmem_wlen = len; dmem_wvalid = 1'b1;
    #1;
    check("store_wready", {31'b0, dmem_wready}, 32'd1);
    tick();
    dmem_wvalid = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a);
    tick();
    dmem_raddr = a; dmem_rvalid = 1'b1;
    #1;
    check("load_rready", {31'b0, dmem_rready}, 32'd1);
    tick();
    dmem_rvalid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_ready"}, {31'b0, imem_ready}, 32'd0);
    check({tag, "_imem_rvalid"}, {31'b0, imem_rdata_valid}, 32'd0);
    check({tag, "_imem_rdata"}, imem_rdata, 32'd0);
    check({tag, "_dmem_rvalid"}, {31'b0, dmem_rdata_valid}, 32'd0);
    check({tag, "_dmem_rdata"}, dmem_rdata, 32'd0);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
    check({tag, "_err_mis"}, {31'b0, err_misaligned}, 32'd0);
    check({tag, "_err_to"}, {31'b0, err_timeout}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, stall, wc, rc, ic;
    logic found, w, r, i, err_before;

    rst = 1'b1;
    imem_addr = '0; imem_valid = 1'b0; imem_rdata_ready = 1'b0;
    dmem_raddr = '0; dmem_rvalid = 1'b0; dmem_rdata_ready = 1'b0;
    dmem_waddr = '0; dmem_wdata = '0; dmem_wlen = '0; dmem_wvalid = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // Fetch at minimum latency, held until the core accepts it.
    exp_mem.push_back('{1'b0, 32'h8000_0000, 32'h0, 4'h0});
    exp_imem.push_back(32'h0000_0413);
    tick();
    imem_addr = 32'h8000_0000; imem_valid = 1'b1;
    #1;
    check("fetch_ready", {31'b0, imem_ready}, 32'd1);
    tick();
    imem_valid = 1'b0;
    lat = 0; found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      #1;
      if (imem_rdata_valid) begin found = 1'b1; lat = k; end
      else tick();
    end
    check("fetch_latency", lat, 3);
    repeat (2) begin
      tick(); #1;
      check("fetch_hold_valid", {31'b0, imem_rdata_valid}, 32'd1);
      check("fetch_hold_data", imem_rdata, 32'h0000_0413);
    end
    imem_rdata_ready = 1'b1;
    dmem_rdata_ready = 1'b1;
    tick(); #1;
    check("fetch_consumed", {31'b0, imem_rdata_valid}, 32'd0);

    // Legal stores: byte at offset 3, halfword at offset 2, full word.
    exp_mem.push_back('{1'b1, 32'h8000_1000, 32'hAB00_0000, 4'b1000});
    do_store(32'h8000_1003, 32'h0000_00AB, 3'd1);
    repeat (2) tick();
    exp_mem.push_back('{1'b1, 32'h8000_1004, 32'h1234_0000, 4'b1100});
    do_store(32'h8000_1006, 32'hFFFF_1234, 3'd2);
    repeat (2) tick();
    exp_mem.push_back('{1'b1, 32'h8000_1008, 32'hCAFE_F00D, 4'b1111});
    do_store(32'h8000_1008, 32'hCAFE_F00D, 3'd4);
    repeat (2) tick();
    check("no_err_mis_yet", {31'b0, err_misaligned}, 32'd0);

    // Misaligned halfword: acknowledged, no memory access, sticky error.
    do_store(32'h8000_1001, 32'h0000_1234, 3'd2);
    #1;
    check("mis_no_req", {31'b0, mem_req}, 32'd0);
    check("mis_err", {31'b0, err_misaligned}, 32'd1);
    repeat (3) tick();

    // All three channels at once: write, then load, then fetch.
    exp_mem.push_back('{1'b1, 32'h8000_1010, 32'h0000_00EE, 4'b0001});
    exp_mem.push_back('{1'b0, 32'h8000_2004, 32'h0, 4'h0});
    exp_mem.push_back('{1'b0, 32'h8000_0004, 32'h0, 4'h0});
    exp_dmem.push_back(32'h1122_3344);
    exp_imem.push_back(32'h0010_0093);
    tick();
    dmem_waddr = 32'h8000_1010; dmem_wdata = 32'h0000_00EE; dmem_wlen = 3'd1; dmem_wvalid = 1'b1;
    dmem_raddr = 32'h8000_2004; dmem_rvalid = 1'b1;
    imem_addr  = 32'h8000_0004; imem_valid = 1'b1;
    wc = 0; rc = 0; ic = 0;
    for (int cyc = 0; cyc < 60 && (dmem_wvalid || dmem_rvalid || imem_valid); cyc++) begin
      #1;
      w = dmem_wready; r = dmem_rready; i = imem_ready;
      if (cyc == 0) check("simul_first_grant", {29'b0, w, r, i}, 32'b100);
      if (w || r || i) check("simul_one_ready", 32'(w) + 32'(r) + 32'(i), 32'd1);
      wc += 32'(w); rc += 32'(r); ic += 32'(i);
      tick();
      if (w) dmem_wvalid = 1'b0;
      if (r) dmem_rvalid = 1'b0;
      if (i) imem_valid  = 1'b0;
    end
    check("simul_wready_pulses", wc, 1);
    check("simul_rready_pulses", rc, 1);
    check("simul_iready_pulses", ic, 1);
    dmem_wvalid = 1'b0; dmem_rvalid = 1'b0; imem_valid = 1'b0;
    repeat (15) tick();

    // Read data arriving in the same cycle the timeout would fire: data wins.
    rv_wait = TO - 1;
    exp_mem.push_back('{1'b0, 32'h8000_3000, 32'h0, 4'h0});
    exp_dmem.push_back(32'h5566_7788);
    do_load(32'h8000_3000);
    repeat (15) tick();
    check("race_no_timeout", {31'b0, err_timeout}, 32'd0);

    // Stalled grant, then a response that never comes.
    gnt_wait = 5; rv_wait = -1;
    exp_mem.push_back('{1'b0, 32'h8000_2004, 32'h0, 4'h0});
    exp_dmem.push_back(32'hDEAD_BEEF);
    do_load(32'h8000_2004);
    stall = 0; found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (mem_gnt) found = 1'b1;
      else begin
        check("stall_req", {31'b0, mem_req}, 32'd1);
        check("stall_addr", mem_addr, 32'h8000_2004);
        stall++;
        tick();
      end
    end
    check("stall_cycles", stall, 5);
    gnt_wait = 0;
    lat = 0; found = 1'b0; err_before = 1'b1;
    for (int k = 1; k <= 40 && !found; k++) begin
      if (k > 1) err_before = err_timeout;
      tick(); #1;
      if (dmem_rdata_valid) begin found = 1'b1; lat = k; end
    end
    check("timeout_latency", lat, TO + 1);
    check("timeout_err_before", {31'b0, err_before}, 32'd0);
    check("timeout_err", {31'b0, err_timeout}, 32'd1);
    check("timeout_data", dmem_rdata, 32'hDEAD_BEEF);
    repeat (3) tick();
    rv_wait = 0;

    // Reset while waiting for a read; the late response must be dropped.
    rv_wait = 4;
    exp_mem.push_back('{1'b0, 32'h8000_0000, 32'h0, 4'h0});
    tick();
    imem_addr = 32'h8000_0000; imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(); #1;
      if (imem_rdata_valid) check("rst_no_valid", {31'b0, imem_rdata_valid}, 32'd0);
    end
    check_reset_outputs("post_rst");
    rv_wait = 0;

    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_imem_drained", exp_imem.size(), 0);
    check("exp_dmem_drained", exp_dmem.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Memory-side arbiter that sits directly downstream of the CPU core's instruction-fetch and data-access channels. It merges the imem read channel, the dmem read channel and the dmem write channel onto one shared memory port. It serialises transactions, generates byte strobes for sub-word stores, and buffers read data until the core accepts it. A response timeout guarantees forward progress if memory never answers.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT_RESP before a forced error response (1..65535).
- `ERR_DATA`, 32'hdeadbeef: read data returned on timeout.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `imem_addr` in 32: fetch address.
- `imem_valid` in 1: fetch request.
- `imem_ready` out 1: fetch request accepted this cycle.
- `imem_rdata` out 32: fetched word.
- `imem_rdata_valid` out 1: fetched word present.
- `imem_rdata_ready` in 1: core consumes fetched word.
- `dmem_raddr` in 32: load address.
- `dmem_rvalid` in 1: load request.
- `dmem_rready` out 1: load request accepted.
- `dmem_rdata` out 32: loaded word, unshifted, aligned word at addr[31:2].
- `dmem_rdata_valid` out 1: load data present.
- `dmem_rdata_ready` in 1: core consumes load data.
- `dmem_waddr` in 32: store address.
- `dmem_wdata` in 32: store data, LSB-justified.
- `dmem_wlen` in 3: store size in bytes (1, 2, 4).
- `dmem_wvalid` in 1: store request.
- `dmem_wready` out 1: store accepted.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `mem_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `mem_wdata` out 32: store data shifted left by 8*addr[1:0].
- `mem_wstrb` out 4: byte enables.
- `mem_gnt` in 1: memory accepts request.
- `mem_rdata` in 32: read data.
- `mem_rvalid` in 1: read data valid.
- `err_misaligned` out 1: sticky, illegal store seen.
- `err_timeout` out 1: sticky, read timeout seen.

## Operation
- States: IDLE, REQ, WAIT_RESP, HOLD_RESP.
- IDLE: the winner is chosen with fixed priority: dmem write > dmem read > imem read. The winner's ready is combinational (state==IDLE && its valid). Losers see ready=0. The address, data and kind of the accepted request are latched. Next state is REQ.
- Store legality: wlen=1 with any offset; wlen=2 with addr[1:0] in {0,2}; wlen=4 with addr[1:0]==0. Strobes are 4'b0001<<off, 4'b0011<<off and 4'b1111 respectively.
- Illegal store (other wlen or offset): wready still pulses, no memory access is made, err_misaligned is set, and the state stays IDLE.
- REQ: mem_req=1 with stable address, data, we and strobe until mem_gnt. On gnt: a write returns to IDLE; a read goes to WAIT_RESP and clears the timeout counter.
- WAIT_RESP: when mem_rvalid=1, capture mem_rdata into the response buffer for the source channel and go to HOLD_RESP. The counter increments each cycle. When the counter reaches TIMEOUT, capture ERR_DATA, set err_timeout, and go to HOLD_RESP.
- HOLD_RESP: the source channel's rdata_valid=1 and rdata is stable. On rdata_ready, go to IDLE.
- mem_rvalid is ignored in any state other than WAIT_RESP.
- Both err flags clear only on rst.

## Timing
- Reset values: all ready/valid/req outputs 0; rdata buses 0; mem_addr, mem_wdata, mem_wstrb, mem_we 0; err flags 0; state IDLE; counter 0.
- Read, best case: accept at cycle 0; mem_req in cycle 1 with gnt in the same cycle; mem_rvalid in cycle 2; rdata_valid in cycle 3. Total 3 cycles from accept to data.
- Write, best case: accept at cycle 0; mem_req+gnt in cycle 1; next accept possible in cycle 2.
- rdata_valid with rdata_ready in the same cycle: consumed, IDLE next cycle, new accept one cycle later. There is no same-cycle back-to-back.
- Simultaneous wvalid, rvalid and imem_valid: only wready asserts. The load wins the next IDLE cycle, then the fetch.
- mem_rvalid arriving in the same cycle the counter hits TIMEOUT: the real data wins and err_timeout is not set.
- rst during any state: the state machine returns to IDLE at that edge, and any in-flight response is dropped without a valid pulse.

## Structure
- Shared package: the state encoding, the source encoding (SRC_IMEM, SRC_DREAD, SRC_DWRITE) and a function `store_strobe(wlen, off)` returning {legal, strb[3:0]}.
- One sub-module, `cpu_mem_store_align`. It is combinational and computes wdata shift, strobe and legality from wlen, addr[1:0] and wdata.
- The timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- Fetch at 0x80000000, memory returns 0x00000413 with gnt and rvalid at minimum latency -> imem_rdata_valid in cycle 3 with 0x00000413; held until imem_rdata_ready.
- Byte store wlen=1 at 0x80001003 with wdata 0xAB -> mem_addr 0x80001000, wstrb 4'b1000, mem_wdata 0xAB000000, mem_we=1.
- Halfword store at 0x80001001 -> wready pulse, no mem_req, err_misaligned=1.
- wvalid, dmem_rvalid and imem_valid all asserted in the same cycle -> memory order is write, load, fetch; each ready pulses exactly once.
- mem_gnt held 0 for 5 cycles -> mem_req and mem_addr stable throughout. Then rvalid never arrives with TIMEOUT=8 -> dmem_rdata=0xdeadbeef and err_timeout=1 eight cycles after gnt.
- rst in WAIT_RESP followed by a late mem_rvalid -> no rdata_valid and all outputs at their reset values.
